// File: rtl/placement_pkg.sv
// Shared definitions for the placement cost evaluator.
// Holds FSM state encoding, unplaced-node marker and width defaults.
package placement_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;

    // Coordinate value marking a node the placer never placed
    localparam int POS_UNPLACED = -1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_E_RD,
        S_E_LAT,
        S_A_RD,
        S_A_LAT,
        S_B_RD,
        S_B_LAT,
        S_DIFF,
        S_ACC
    } state_t;

endpackage

// File: rtl/placement_eval_edge_cost.sv
// Combinational per-edge cost terms from the two endpoint positions.
// In: ax, ay, bx, by (signed). Out: dx, dy, manh_term, hop_term, unplaced.
module edge_cost
    import placement_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] ax,
    input  logic [DATA_W-1:0] ay,
    input  logic [DATA_W-1:0] bx,
    input  logic [DATA_W-1:0] by,
    output logic [DATA_W-1:0] dx,
    output logic [DATA_W-1:0] dy,
    output logic [DATA_W-1:0] manh_term,
    output logic [DATA_W-1:0] hop_term,
    output logic              unplaced
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);
    localparam logic [DATA_W-1:0] UNP = DATA_W'(POS_UNPLACED);

    logic [DATA_W-1:0] sx;
    logic [DATA_W-1:0] sy;

    assign sx = ax - bx;
    assign sy = ay - by;

    // Two's-complement absolute value
    assign dx = sx[DATA_W-1] ? (~sx + ONE) : sx;
    assign dy = sy[DATA_W-1] ? (~sy + ONE) : sy;

    assign manh_term = dx + dy - ONE;

    // ceil(d/2) = (d >> 1) + d[0]
    assign hop_term = (dx >> 1) + DATA_W'(dx[0])
                    + (dy >> 1) + DATA_W'(dy[0]) - ONE;

    assign unplaced = (ax == UNP) || (ay == UNP)
                   || (bx == UNP) || (by == UNP);

endmodule

// File: rtl/placement_eval.sv
// Walks the edge list, fetches endpoint positions and sums wire costs.
// Ports: start/busy/done control, edge and position memory read ports, costs.
module placement_eval
    import placement_pkg::*;
#(
    parameter int N_EDGE = 22,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              edge_re,
    output logic [ADDR_W-1:0] edge_addr,
    input  logic [DATA_W-1:0] ea_data,
    input  logic [DATA_W-1:0] eb_data,
    output logic              pos_re,
    output logic [ADDR_W-1:0] pos_addr,
    input  logic [DATA_W-1:0] pos_x_data,
    input  logic [DATA_W-1:0] pos_y_data,
    output logic [DATA_W-1:0] cost_manh,
    output logic [DATA_W-1:0] cost_1hop,
    output logic              invalid,
    output logic [7:0]        skipped
);

    state_t state;
    state_t nxt;

    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] ax;
    logic [DATA_W-1:0] ay;
    logic [DATA_W-1:0] bx;
    logic [DATA_W-1:0] by;
    logic [DATA_W-1:0] manh_q;
    logic [DATA_W-1:0] hop_q;
    logic              unpl_q;

    logic [DATA_W-1:0] dx_w;
    logic [DATA_W-1:0] dy_w;
    logic [DATA_W-1:0] manh_w;
    logic [DATA_W-1:0] hop_w;
    logic              unpl_w;
    logic              last;
    logic              go;

    // Distances are only needed inside the term calculation
    logic [2*DATA_W-1:0] unused_d;
    assign unused_d = {dx_w, dy_w};

    edge_cost #(.DATA_W(DATA_W)) u_cost (
        .ax        (ax),
        .ay        (ay),
        .bx        (bx),
        .by        (by),
        .dx        (dx_w),
        .dy        (dy_w),
        .manh_term (manh_w),
        .hop_term  (hop_w),
        .unplaced  (unpl_w)
    );

    assign last = (idx == ADDR_W'(N_EDGE - 1));
    // A start coinciding with the done pulse is deliberately dropped
    assign go = start && !done;

    assign busy      = (state != S_IDLE);
    assign edge_re   = (state == S_E_RD);
    assign edge_addr = idx;
    assign pos_re    = (state == S_A_RD) || (state == S_B_RD);
    assign pos_addr  = (state == S_B_RD) ? ADDR_W'(b) : ADDR_W'(a);

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (go) nxt = S_E_RD;
            S_E_RD:  nxt = S_E_LAT;
            S_E_LAT: nxt = S_A_RD;
            S_A_RD:  nxt = S_A_LAT;
            S_A_LAT: nxt = S_B_RD;
            S_B_RD:  nxt = S_B_LAT;
            S_B_LAT: nxt = S_DIFF;
            S_DIFF:  nxt = S_ACC;
            S_ACC:   nxt = last ? S_IDLE : S_E_RD;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            a         <= '0;
            b         <= '0;
            ax        <= '0;
            ay        <= '0;
            bx        <= '0;
            by        <= '0;
            manh_q    <= '0;
            hop_q     <= '0;
            unpl_q    <= 1'b0;
            cost_manh <= '0;
            cost_1hop <= '0;
            invalid   <= 1'b0;
            skipped   <= '0;
            done      <= 1'b0;
        end else begin
            state <= nxt;
            done  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        idx       <= '0;
                        cost_manh <= '0;
                        cost_1hop <= '0;
                        invalid   <= 1'b0;
                        skipped   <= '0;
                    end
                end
                S_E_LAT: begin
                    a <= ea_data;
                    b <= eb_data;
                end
                S_A_LAT: begin
                    ax <= pos_x_data;
                    ay <= pos_y_data;
                end
                S_B_LAT: begin
                    bx <= pos_x_data;
                    by <= pos_y_data;
                end
                S_DIFF: begin
                    manh_q <= manh_w;
                    hop_q  <= hop_w;
                    unpl_q <= unpl_w;
                end
                S_ACC: begin
                    if (unpl_q) begin
                        invalid <= 1'b1;
                        if (skipped != 8'hFF)
                            skipped <= skipped + 8'd1;
                    end else begin
                        cost_manh <= cost_manh + manh_q;
                        cost_1hop <= cost_1hop + hop_q;
                    end
                    idx <= idx + ADDR_W'(1);
                    if (last)
                        done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_placement_eval.sv
// Scoreboard bench for placement_eval with behavioural edge/position memories.
// Expected costs are queued at start and compared on the done pulse.
module tb_placement_eval;

    localparam int NE = 22;

    typedef struct packed {
        logic [31:0] manh;
        logic [31:0] hop;
        logic        inv;
        logic [7:0]  skp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        edge_re;
    logic [31:0] edge_addr;
    logic [31:0] ea_data;
    logic [31:0] eb_data;
    logic        pos_re;
    logic [31:0] pos_addr;
    logic [31:0] pos_x_data;
    logic [31:0] pos_y_data;
    logic [31:0] cost_manh;
    logic [31:0] cost_1hop;
    logic        invalid;
    logic [7:0]  skipped;

    logic [31:0] ea_mem [0:31];
    logic [31:0] eb_mem [0:31];
    logic [31:0] px_mem [0:31];
    logic [31:0] py_mem [0:31];

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_ere = 0;
    int n_pre = 0;
    int n_both = 0;
    int n_seq = 0;
    int n_done = 0;
    int run_idx = 0;

    always #5 clk = ~clk;

    placement_eval #(.N_EDGE(NE), .DATA_W(32), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .edge_re    (edge_re),
        .edge_addr  (edge_addr),
        .ea_data    (ea_data),
        .eb_data    (eb_data),
        .pos_re     (pos_re),
        .pos_addr   (pos_addr),
        .pos_x_data (pos_x_data),
        .pos_y_data (pos_y_data),
        .cost_manh  (cost_manh),
        .cost_1hop  (cost_1hop),
        .invalid    (invalid),
        .skipped    (skipped)
    );

    // Synchronous-read memories: data follows re by one cycle and holds
    always @(posedge clk) begin
        if (edge_re) begin
            ea_data <= ea_mem[edge_addr[4:0]];
            eb_data <= eb_mem[edge_addr[4:0]];
        end
        if (pos_re) begin
            pos_x_data <= px_mem[pos_addr[4:0]];
            pos_y_data <= py_mem[pos_addr[4:0]];
        end
    end

    // Protocol monitor
    always @(negedge clk) begin
        if (edge_re && pos_re) n_both++;
        if (pos_re) n_pre++;
        if (done) n_done++;
        if (!busy) run_idx = 0;
        else if (edge_re) begin
            if (edge_addr != run_idx) n_seq++;
            run_idx++;
            n_ere++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_node(input int n, input int x, input int y);
        px_mem[n] = x;
        py_mem[n] = y;
    endtask

    task automatic set_edge(input int e, input int a, input int b);
        ea_mem[e] = a;
        eb_mem[e] = b;
    endtask

    task automatic push(input int m, input int h, input logic i, input int s);
        exp_t e;
        e.manh = m;
        e.hop  = h;
        e.inv  = i;
        e.skp  = 8'(s);
        sb_q.push_back(e);
    endtask

    function automatic exp_t model();
        exp_t r;
        int ax, ay, bx, by, dx, dy;
        r = '0;
        for (int e = 0; e < NE; e++) begin
            ax = px_mem[ea_mem[e][4:0]];
            ay = py_mem[ea_mem[e][4:0]];
            bx = px_mem[eb_mem[e][4:0]];
            by = py_mem[eb_mem[e][4:0]];
            if (ax == -1 || ay == -1 || bx == -1 || by == -1) begin
                r.inv = 1'b1;
                if (r.skp != 8'hFF) r.skp = r.skp + 8'd1;
            end else begin
                dx = ax - bx;
                dy = ay - by;
                if (dx < 0) dx = -dx;
                if (dy < 0) dy = -dy;
                r.manh = r.manh + 32'(dx + dy - 1);
                r.hop  = r.hop + 32'((dx + 1) / 2 + (dy + 1) / 2 - 1);
            end
        end
        return r;
    endfunction

    task automatic do_run(input string nm, input int hold);
        int lat, hcnt, b_ere, b_pre, b_both, b_seq, b_done;
        exp_t e;
        b_ere = n_ere; b_pre = n_pre; b_both = n_both;
        b_seq = n_seq; b_done = n_done;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        hcnt = 1;
        if (hcnt >= hold) start = 1'b0;
        check({nm, ".busy_up"}, busy, 1);
        lat = 0;
        while (lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
            hcnt++;
            if (hcnt >= hold) start = 1'b0;
            if (done) break;
        end
        check({nm, ".latency"}, lat, 8 * NE);
        check({nm, ".busy_at_done"}, busy, 0);
        if (sb_q.size() == 0) begin
            e = '0;
            check({nm, ".sb_empty"}, 1, 0);
        end else
            e = sb_q.pop_front();
        check({nm, ".manh"}, cost_manh, e.manh);
        check({nm, ".hop"}, cost_1hop, e.hop);
        check({nm, ".invalid"}, invalid, e.inv);
        check({nm, ".skipped"}, skipped, e.skp);
        @(posedge clk);
        #1;
        start = 1'b0;
        check({nm, ".done_width"}, done, 0);
        check({nm, ".idle"}, busy, 0);
        repeat (10) @(posedge clk);
        #1;
        check({nm, ".manh_hold"}, cost_manh, e.manh);
        check({nm, ".edge_reads"}, n_ere - b_ere, NE);
        check({nm, ".pos_reads"}, n_pre - b_pre, 2 * NE);
        check({nm, ".re_overlap"}, n_both - b_both, 0);
        check({nm, ".addr_seq"}, n_seq - b_seq, 0);
        check({nm, ".done_count"}, n_done - b_done, 1);
    endtask

    task automatic scen_a();
        for (int n = 0; n < 32; n++) set_node(n, -1, -1);
        set_node(0, 0, 0);
        set_node(1, 2, 3);
        set_node(2, 2, 4);
        set_node(3, -1, 5);
        set_edge(0, 0, 1);
        set_edge(1, 1, 3);
        set_edge(2, 1, 2);
        for (int e = 3; e < 32; e++) set_edge(e, 3, 0);
    endtask

    initial begin
        int b_done;
        exp_t m;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.edge_re", edge_re, 0);
        check("rst.pos_re", pos_re, 0);
        check("rst.edge_addr", edge_addr, 0);
        check("rst.pos_addr", pos_addr, 0);
        check("rst.manh", cost_manh, 0);
        check("rst.hop", cost_1hop, 0);
        check("rst.invalid", invalid, 0);
        check("rst.skipped", skipped, 0);
        reset = 1'b0;

        // Two valid edges around an invalid one, rest invalid
        scen_a();
        push(4, 2, 1'b1, 20);
        do_run("basic", 1);

        // Negative differences: A=(4,1), B=(1,4)
        for (int n = 0; n < 32; n++) set_node(n, -1, -1);
        set_node(4, 4, 1);
        set_node(5, 1, 4);
        set_node(3, 7, -1);
        set_edge(0, 4, 5);
        for (int e = 1; e < 32; e++) set_edge(e, 3, 3);
        push(5, 3, 1'b1, 21);
        do_run("absdiff", 1);

        // Zero-length edges each contribute -1
        set_node(0, 0, 0);
        for (int e = 0; e < 32; e++) set_edge(e, 0, 0);
        push(-NE, -NE, 1'b0, 0);
        do_run("zero_len", 1);

        // start held through the run and the done cycle, then re-run
        scen_a();
        push(4, 2, 1'b1, 20);
        do_run("start_held", 8 * NE + 2);
        push(4, 2, 1'b1, 20);
        do_run("restart", 1);

        // Reset mid-edge-1 aborts with no done pulse
        b_done = n_done;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort.pre_cost", cost_manh, 4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort.busy", busy, 0);
        check("abort.manh", cost_manh, 0);
        check("abort.hop", cost_1hop, 0);
        check("abort.invalid", invalid, 0);
        check("abort.skipped", skipped, 0);
        repeat (200) @(posedge clk);
        #1;
        check("abort.no_done", n_done - b_done, 0);
        push(4, 2, 1'b1, 20);
        do_run("post_abort", 1);

        // Random placements with a couple of unplaced nodes
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < 32; n++)
                set_node(n, int'($urandom_range(0, 400)) - 200,
                         int'($urandom_range(0, 400)) - 200);
            set_node(30, -1, 9);
            set_node(31, 9, -1);
            for (int e = 0; e < 32; e++)
                set_edge(e, int'($urandom_range(0, 31)),
                         int'($urandom_range(0, 31)));
            m = model();
            sb_q.push_back(m);
            do_run("random", 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/placement_eval.md
Name: placement_eval

Overview:
- Downstream cost stage for the random placement engine.
- After placement finishes, walks the edge list (EA/EB ROMs) and reads each endpoint's X/Y from the position RAMs.
- Accumulates two wirelength costs: Manhattan (dx+dy-1) and 1-hop (ceil(dx/2)+ceil(dy/2)-1).
- Drives external synchronous-read memories only and produces final cost registers plus a done pulse.

Parameters:
- N_EDGE, 22, number of edges to evaluate (must be >= 1).
- DATA_W, 32, data width of edge/position words and cost accumulators.
- ADDR_W, 32, address width of edge and position memories.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin evaluation; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when results are valid.
- edge_re  output  1  read enable shared by EA and EB ROMs.
- edge_addr  output  ADDR_W  edge index, shared by EA and EB.
- ea_data  input  DATA_W  node A id of the edge.
- eb_data  input  DATA_W  node B id of the edge.
- pos_re  output  1  read enable shared by pos_X and pos_Y RAMs.
- pos_addr  output  ADDR_W  node id.
- pos_x_data  input  DATA_W  signed X of the node.
- pos_y_data  input  DATA_W  signed Y of the node.
- cost_manh  output  DATA_W  signed Manhattan sum.
- cost_1hop  output  DATA_W  signed 1-hop sum.
- invalid  output  1  sticky flag: some endpoint unplaced (X or Y == -1).
- skipped  output  8  count of edges skipped as invalid (saturating at 255).

Behaviour:
- Memory model: data is valid the cycle after re is high and is held until the next re.
- Reset values:
  - state IDLE; busy=0, done=0, edge_re=0, pos_re=0.
  - edge_addr=0, pos_addr=0.
  - cost_manh=0, cost_1hop=0, invalid=0, skipped=0.
- Reset asserted mid-operation aborts immediately, with no done pulse.
- States and transitions:
  - IDLE: on start, clear accumulators, invalid and skipped; set i=0; go to E_RD.
  - E_RD: edge_re=1, edge_addr=i.
  - E_LAT: latch a=ea_data, b=eb_data.
  - A_RD: pos_re=1, pos_addr=a.
  - A_LAT: latch ax, ay.
  - B_RD: pos_re=1, pos_addr=b.
  - B_LAT: latch bx, by.
  - DIFF: dx=|ax-bx|, dy=|ay-by| (two's-complement negate when negative).
  - ACC:
    - If any of ax, ay, bx, by == -1: set invalid, increment skipped, no accumulation.
    - Otherwise: cost_manh += dx+dy-1; cost_1hop += (dx>>1)+dx[0] + (dy>>1)+dy[0] - 1.
    - Then i++; if i == N_EDGE-1 before the increment, go to IDLE and pulse done; else go to E_RD.
- Throughput: exactly 8 cycles per edge.
- done goes high 8*N_EDGE clock edges after the edge that sampled start, for one cycle.
- busy drops in the same cycle done rises.
- Costs are signed DATA_W and wrap on overflow (no saturation).
- An edge with dx=dy=0 contributes -1 to both sums; this is not flagged.
- start while busy is ignored. start in the same cycle as done is ignored; it is sampled from the next cycle.
- Results hold stable from done until the next accepted start.
- edge_re and pos_re are single-cycle pulses, never high in the same cycle.

Decomposition:
- Shared package placement_pkg holds:
  - state encoding for this FSM;
  - POS_UNPLACED = -1;
  - DATA_W/ADDR_W defaults.
- One combinational sub-module, edge_cost: inputs ax, ay, bx, by; outputs dx, dy, manh_term, hop_term, unplaced.
  - Instantiated once and registered in DIFF/ACC.

Test Plan:
1. N_EDGE=2; edges (0,1),(1,2); pos node0=(0,0), node1=(2,3), node2=(2,4); pulse start -> done exactly 16 edges later, cost_manh=4, cost_1hop=2, invalid=0, skipped=0.
2. Single edge with A=(4,1), B=(1,4) -> dx=3, dy=3, cost_manh=5, cost_1hop=3 (negative-difference abs path).
3. Edge whose node B has X=-1 -> invalid=1, skipped=1, costs unchanged from the preceding edges; the next valid edge still accumulates.
4. start held high for 40 cycles during a run -> exactly one done pulse; re-issue start after done -> accumulators restart from 0 and give the identical result.
5. reset asserted at cycle 5 of edge 1 -> next cycle busy=0, costs=0, no done pulse; a new start completes normally.
6. Protocol check over a full 22-edge run -> edge_re/pos_re never high together, 3 reads per edge, edge_addr sequence 0..21.
